// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline hazard status inputs and latch control outputs
interface hazard_ctrl_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Pipeline status seen by the hazard controller
    logic             ihit;
    logic             dhit;
    logic             em_dREN;
    logic             em_dWEN;
    logic             em_pcsrc;
    logic             em_halt;
    logic             de_memread;
    logic [REG_W-1:0] de_wsel;
    logic [REG_W-1:0] fd_rs;
    logic [REG_W-1:0] fd_rt;

    // Latch controls and status driven by the hazard controller
    logic             pc_en;
    logic             FDen;
    logic             DEen;
    logic             EMen;
    logic             MWen;
    logic             FDflush;
    logic             DEflush;
    logic             EMflush;
    logic             MWflush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, em_dREN, em_dWEN, em_pcsrc, em_halt,
               de_memread, de_wsel, fd_rs, fd_rt,
        input  pc_en, FDen, DEen, EMen, MWen,
               FDflush, DEflush, EMflush, MWflush,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, em_dREN, em_dWEN, em_pcsrc, em_halt,
               de_memread, de_wsel, fd_rs, fd_rt,
        output pc_en, FDen, DEen, EMen, MWen,
               FDflush, DEflush, EMflush, MWflush,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - 5-stage pipeline hazard FSM (RUN/DRAIN/HALTED); perf counters under HAZARD_PERF_CNT_EN
module hazard_ctrl_unit #(
    parameter int REG_W     = 5,
    parameter int LU_STALL  = 1,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    hazard_ctrl_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] LU_LOAD = 2'(LU_STALL - 1);
    localparam logic [3:0] DR_LOAD = 4'(DRAIN_CYC);

    state_t     fsm_q, fsm_d;
    logic [1:0] lu_q, lu_d;
    logic [3:0] dr_q, dr_d;

    logic dwait;
    logic luse;

    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_flush, de_flush, em_flush, mw_flush;
    logic halted;

    // A memory op in EM that has not completed freezes the front of the pipe
    assign dwait = (bus.em_dREN | bus.em_dWEN) & ~bus.dhit;

    // Load in DE whose destination is consumed by the instruction in FD (r0 never hazards)
    assign luse = bus.de_memread
                & (bus.de_wsel != {REG_W{1'b0}})
                & ((bus.de_wsel == bus.fd_rs) | (bus.de_wsel == bus.fd_rt));

    // State, load-use countdown and drain countdown registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q <= ST_RUN;
            lu_q  <= 2'd0;
            dr_q  <= 4'd0;
        end else begin
            fsm_q <= fsm_d;
            lu_q  <= lu_d;
            dr_q  <= dr_d;
        end
    end

    // Next-state and latch control decode, highest priority hazard first
    always_comb begin
        fsm_d    = fsm_q;
        lu_d     = lu_q;
        dr_d     = dr_q;
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        mw_flush = 1'b0;
        halted   = 1'b0;

        if (RST) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
        end else begin
            case (fsm_q)
                ST_RUN: begin
                    if (dwait) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_en    = 1'b0;
                        em_en    = 1'b0;
                        mw_flush = 1'b1;
                    end else if (bus.em_halt) begin
                        fsm_d    = ST_DRAIN;
                        dr_d     = DR_LOAD;
                        lu_d     = 2'd0;
                        pc_en    = 1'b0;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (bus.em_pcsrc) begin
                        lu_d     = 2'd0;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (luse || (lu_q != 2'd0)) begin
                        lu_d     = luse ? LU_LOAD : (lu_q - 2'd1);
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end else if (!bus.ihit) begin
                        pc_en    = 1'b0;
                        fd_flush = 1'b1;
                    end
                end

                ST_DRAIN: begin
                    pc_en = 1'b0;
                    if (dwait) begin
                        // Same freeze as in RUN; the drain countdown waits for memory
                        fd_en    = 1'b0;
                        de_en    = 1'b0;
                        em_en    = 1'b0;
                        mw_flush = 1'b1;
                    end else begin
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                        if (dr_q == 4'd0) begin
                            fsm_d = ST_HALTED;
                        end else begin
                            dr_d = dr_q - 4'd1;
                        end
                    end
                end

                ST_HALTED: begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    de_en  = 1'b0;
                    em_en  = 1'b0;
                    mw_en  = 1'b0;
                    halted = 1'b1;
                end

                default: begin
                    fsm_d = ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc_en   = pc_en;
    assign bus.FDen    = fd_en;
    assign bus.DEen    = de_en;
    assign bus.EMen    = em_en;
    assign bus.MWen    = mw_en;
    assign bus.FDflush = fd_flush;
    assign bus.DEflush = de_flush;
    assign bus.EMflush = em_flush;
    assign bus.MWflush = mw_flush;
    assign bus.halted  = halted;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             redirect;
    logic             stall_evt;

    // A redirect is accepted only when nothing above it in priority fired
    assign redirect  = (fsm_q == ST_RUN) & ~dwait & ~bus.em_halt & bus.em_pcsrc;
    assign stall_evt = ~pc_en & (fsm_q != ST_HALTED);

    // Saturating performance counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= {CNT_W{1'b0}};
            flush_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (redirect && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

    logic clk;
    logic rst;

    hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(16)) ba ();
    hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(2))  bb ();

    hazard_ctrl_unit #(.REG_W(5), .LU_STALL(2), .DRAIN_CYC(2), .CNT_W(16)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (ba)
    );

    hazard_ctrl_unit #(.REG_W(5), .LU_STALL(1), .DRAIN_CYC(0), .CNT_W(2)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // {pc_en, FDen, DEen, EMen, MWen, FDflush, DEflush, EMflush, MWflush}
    localparam logic [8:0] C_RUN = 9'b11111_0000;
    localparam logic [8:0] C_RST = 9'b00000_1111;
    localparam logic [8:0] C_LU  = 9'b00111_0100;
    localparam logic [8:0] C_DW  = 9'b00001_0001;
    localparam logic [8:0] C_PC  = 9'b11111_1100;
    localparam logic [8:0] C_HLT = 9'b01111_1100;
    localparam logic [8:0] C_IM  = 9'b01111_1000;
    localparam logic [8:0] C_HD  = 9'b00000_0000;
    localparam logic [8:0] M_ALL = 9'b11111_1111;
    localparam logic [8:0] M_DRW = 9'b11111_0011;

    typedef struct {
        string      name;
        int         dut;
        logic [8:0] ctl;
        logic [8:0] mask;
        logic       halted;
        bit         chk_cnt;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_dut  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_full(input string n, input logic [8:0] c, input logic [8:0] m,
                               input logic h, input bit cc, input int sc, input int fc);
        exp_t e;
        e.name = n; e.dut = cur_dut; e.ctl = c; e.mask = m;
        e.halted = h; e.chk_cnt = cc; e.sc = sc; e.fc = fc;
        sb.push_back(e);
    endtask

    task automatic ex(input string n, input logic [8:0] c, input logic h);
        expect_full(n, c, M_ALL, h, 1'b0, 0, 0);
        tick();
    endtask

    task automatic exc(input string n, input logic [8:0] c, input logic h, input int sc, input int fc);
        expect_full(n, c, M_ALL, h, 1'b1, sc * PERF, fc * PERF);
        tick();
    endtask

    task automatic idle_all();
        ba.ihit = 1'b1; ba.dhit = 1'b0; ba.em_dREN = 1'b0; ba.em_dWEN = 1'b0;
        ba.em_pcsrc = 1'b0; ba.em_halt = 1'b0; ba.de_memread = 1'b0;
        ba.de_wsel = 5'd0; ba.fd_rs = 5'd0; ba.fd_rt = 5'd0;
        bb.ihit = 1'b1; bb.dhit = 1'b0; bb.em_dREN = 1'b0; bb.em_dWEN = 1'b0;
        bb.em_pcsrc = 1'b0; bb.em_halt = 1'b0; bb.de_memread = 1'b0;
        bb.de_wsel = 5'd0; bb.fd_rs = 5'd0; bb.fd_rt = 5'd0;
    endtask

    // Monitor: one scoreboard entry per cycle, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                logic [8:0] act;
                logic       act_h;
                int         act_sc;
                int         act_fc;
                e = sb.pop_front();
                if (e.dut == 0) begin
                    act = {ba.pc_en, ba.FDen, ba.DEen, ba.EMen, ba.MWen,
                           ba.FDflush, ba.DEflush, ba.EMflush, ba.MWflush};
                    act_h  = ba.halted;
                    act_sc = int'(ba.stall_cnt);
                    act_fc = int'(ba.flush_cnt);
                end else begin
                    act = {bb.pc_en, bb.FDen, bb.DEen, bb.EMen, bb.MWen,
                           bb.FDflush, bb.DEflush, bb.EMflush, bb.MWflush};
                    act_h  = bb.halted;
                    act_sc = int'(bb.stall_cnt);
                    act_fc = int'(bb.flush_cnt);
                end
                checks++;
                if ((act & e.mask) !== (e.ctl & e.mask)) begin
                    failures++;
                    $display("FAIL %s ctl actual=%b required=%b (mask %b)", e.name, act, e.ctl, e.mask);
                end
                checks++;
                if (act_h !== e.halted) begin
                    failures++;
                    $display("FAIL %s halted actual=%b required=%b", e.name, act_h, e.halted);
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (act_sc != e.sc) begin
                        failures++;
                        $display("FAIL %s stall_cnt actual=%0d required=%0d", e.name, act_sc, e.sc);
                    end
                    checks++;
                    if (act_fc != e.fc) begin
                        failures++;
                        $display("FAIL %s flush_cnt actual=%0d required=%0d", e.name, act_fc, e.fc);
                    end
                end
            end
        end
    end

    // Stimulus: directed vectors, expected controls pushed as each cycle is driven
    initial begin
        rst = 1'b1;
        idle_all();
        tick();

        // ---------------- DUT A: LU_STALL=2, DRAIN_CYC=2 ----------------
        cur_dut = 0;
        ex("rst0", C_RST, 1'b0);
        ex("rst1", C_RST, 1'b0);
        rst = 1'b0;
        exc("after_rst", C_RUN, 1'b0, 0, 0);

        // Perf: five imem misses and two redirects
        ba.ihit = 1'b0;
        repeat (5) ex("imiss", C_IM, 1'b0);
        ba.ihit = 1'b1; ba.em_pcsrc = 1'b1;
        repeat (2) ex("redirect", C_PC, 1'b0);
        ba.em_pcsrc = 1'b0;
        exc("perf_cnt", C_RUN, 1'b0, 5, 2);

        // Load-use on rs: exactly two bubble cycles
        ba.de_memread = 1'b1; ba.de_wsel = 5'd5; ba.fd_rs = 5'd5; ba.fd_rt = 5'd9;
        ex("lu_rs_c0", C_LU, 1'b0);
        ba.de_memread = 1'b0;
        ex("lu_rs_c1", C_LU, 1'b0);
        ex("lu_rs_done", C_RUN, 1'b0);

        // Load into r0 never stalls
        ba.de_memread = 1'b1; ba.de_wsel = 5'd0; ba.fd_rs = 5'd0;
        ex("lu_r0", C_RUN, 1'b0);

        // Load-use on rt
        ba.de_wsel = 5'd7; ba.fd_rs = 5'd3; ba.fd_rt = 5'd7;
        ex("lu_rt_c0", C_LU, 1'b0);
        ba.de_memread = 1'b0;
        ex("lu_rt_c1", C_LU, 1'b0);
        ex("lu_rt_done", C_RUN, 1'b0);

        // Second load-use during a stall reloads the countdown
        ba.de_memread = 1'b1;
        ex("lu_rl_c0", C_LU, 1'b0);
        ex("lu_rl_c1", C_LU, 1'b0);
        ba.de_memread = 1'b0;
        ex("lu_rl_c2", C_LU, 1'b0);
        ex("lu_rl_done", C_RUN, 1'b0);
        ba.de_wsel = 5'd0; ba.fd_rs = 5'd0; ba.fd_rt = 5'd0;

        // dmem wait dominates a pending redirect
        ba.em_dREN = 1'b1; ba.dhit = 1'b0; ba.em_pcsrc = 1'b1;
        repeat (3) ex("dwait", C_DW, 1'b0);
        ba.dhit = 1'b1;
        ex("dwait_done_redir", C_PC, 1'b0);
        ba.em_dREN = 1'b0; ba.dhit = 1'b0; ba.em_pcsrc = 1'b0;
        ex("dwait_idle", C_RUN, 1'b0);

        // Redirect cancels a pending load-use bubble
        ba.de_memread = 1'b1; ba.de_wsel = 5'd5; ba.fd_rs = 5'd5;
        ex("lu_cancel_c0", C_LU, 1'b0);
        ba.de_memread = 1'b0; ba.em_pcsrc = 1'b1;
        ex("lu_cancel_redir", C_PC, 1'b0);
        ba.em_pcsrc = 1'b0;
        ex("lu_cancel_after", C_RUN, 1'b0);
        ba.de_wsel = 5'd0; ba.fd_rs = 5'd0;

        // Halt together with redirect: halt wins, three drain cycles, then halted
        rst = 1'b1;
        ex("rst_halt", C_RST, 1'b0);
        rst = 1'b0;
        ba.em_halt = 1'b1; ba.em_pcsrc = 1'b1;
        ex("halt_entry", C_HLT, 1'b0);
        ba.em_halt = 1'b0; ba.em_pcsrc = 1'b0;
        ex("drain_2", C_HLT, 1'b0);
        ex("drain_1", C_HLT, 1'b0);
        ex("drain_0", C_HLT, 1'b0);
        exc("halted_0", C_HD, 1'b1, 4, 0);
        ba.em_pcsrc = 1'b1; ba.ihit = 1'b0;
        exc("halted_sticky", C_HD, 1'b1, 4, 0);
        ba.em_pcsrc = 1'b0; ba.ihit = 1'b1;

        // dmem wait inside the drain adds one cycle
        rst = 1'b1;
        ex("rst_dw", C_RST, 1'b0);
        rst = 1'b0;
        ba.em_halt = 1'b1;
        ex("dh_entry", C_HLT, 1'b0);
        ba.em_halt = 1'b0;
        ex("dh_drain_2", C_HLT, 1'b0);
        ba.em_dREN = 1'b1;
        expect_full("dh_drain_wait", C_DW, M_DRW, 1'b0, 1'b0, 0, 0);
        tick();
        ba.em_dREN = 1'b0;
        ex("dh_drain_1", C_HLT, 1'b0);
        ex("dh_drain_0", C_HLT, 1'b0);
        ex("dh_halted", C_HD, 1'b1);

        // Reset in the middle of a drain
        rst = 1'b1;
        ex("rst_md", C_RST, 1'b0);
        rst = 1'b0;
        ba.em_halt = 1'b1;
        ex("md_entry", C_HLT, 1'b0);
        ba.em_halt = 1'b0;
        ex("md_drain", C_HLT, 1'b0);
        rst = 1'b1;
        ex("md_rst", C_RST, 1'b0);
        rst = 1'b0;
        exc("md_run", C_RUN, 1'b0, 0, 0);
        ex("md_run2", C_RUN, 1'b0);

        // ---------------- DUT B: LU_STALL=1, DRAIN_CYC=0, CNT_W=2 ----------------
        cur_dut = 1;
        rst = 1'b1;
        ex("b_rst", C_RST, 1'b0);
        rst = 1'b0;
        exc("b_after_rst", C_RUN, 1'b0, 0, 0);
        bb.de_memread = 1'b1; bb.de_wsel = 5'd2; bb.fd_rt = 5'd2;
        ex("b_lu_c0", C_LU, 1'b0);
        bb.de_memread = 1'b0;
        ex("b_lu_done", C_RUN, 1'b0);
        bb.ihit = 1'b0;
        repeat (6) ex("b_imiss", C_IM, 1'b0);
        bb.ihit = 1'b1;
        exc("b_sat", C_RUN, 1'b0, 3, 0);
        bb.em_halt = 1'b1;
        ex("b_halt_entry", C_HLT, 1'b0);
        bb.em_halt = 1'b0;
        ex("b_drain_0", C_HLT, 1'b0);
        exc("b_halted", C_HD, 1'b1, 3, 0);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
